// File: rtl/vec_chunk_feeder.sv
// Chunked-vector responder: buffers upstream chunks in a circular store and
// serves them first-word-fall-through, one chunk per downstream request.
module vec_chunk_feeder #(
  parameter int InVecLength = 16,
  parameter int WorkingRegs = 4,
  parameter int NBits       = 8,
  parameter int DepthVecs   = 2,
  localparam int C          = InVecLength / WorkingRegs,
  localparam int IdxW       = (C > 1) ? $clog2(C) : 1
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic signed [WorkingRegs-1:0][NBits-1:0]   s_data,
  input  logic                                       s_last,
  input  logic                                       req_chunk_in,
  output logic signed [WorkingRegs-1:0][NBits-1:0]   out_data,
  output logic                                       in_data_ready,
  output logic [IdxW-1:0]                            chunk_idx,
  output logic                                       err_align,
  output logic                                       err_underflow
);

  localparam int D      = DepthVecs * C;
  localparam int PtrW   = (D > 1) ? $clog2(D) : 1;
  localparam int CntW   = $clog2(D + 1);
  localparam int VecW   = $clog2(DepthVecs + 1);
  localparam int ChunkW = WorkingRegs * NBits;

  logic [ChunkW-1:0] store_mem [D];

  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0] count_reg, count_next;
  logic [VecW-1:0] vec_count_reg, vec_count_next;
  logic [IdxW-1:0] wr_idx_reg, wr_idx_next, rd_idx_reg, rd_idx_next;
  logic            err_align_reg, err_align_next;
  logic            err_underflow_reg, err_underflow_next;
  logic            push, pop, vec_done, vec_used;
  logic [ChunkW-1:0] head_chunk;

  always_comb begin
    push     = s_valid && (count_reg < CntW'(D));
    pop      = req_chunk_in && (count_reg != '0);
    vec_done = push && (wr_idx_reg == IdxW'(C - 1));
    vec_used = pop && (rd_idx_reg == IdxW'(C - 1));

    wr_ptr_next        = wr_ptr_reg;
    rd_ptr_next        = rd_ptr_reg;
    count_next         = count_reg;
    vec_count_next     = vec_count_reg;
    wr_idx_next        = wr_idx_reg;
    rd_idx_next        = rd_idx_reg;
    err_align_next     = err_align_reg;
    err_underflow_next = err_underflow_reg;

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PtrW'(D - 1)) ? '0 : wr_ptr_reg + PtrW'(1);
      // Either a length boundary or s_last closes the write-side vector;
      // disagreement between the two is an alignment error.
      if ((wr_idx_reg == IdxW'(C - 1)) || s_last)
        wr_idx_next = '0;
      else
        wr_idx_next = wr_idx_reg + IdxW'(1);
      if (vec_done != s_last)
        err_align_next = 1'b1;
    end

    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PtrW'(D - 1)) ? '0 : rd_ptr_reg + PtrW'(1);
      rd_idx_next = (rd_idx_reg == IdxW'(C - 1)) ? '0 : rd_idx_reg + IdxW'(1);
    end else if (req_chunk_in) begin
      err_underflow_next = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + CntW'(1);
      2'b01:   count_next = count_reg - CntW'(1);
      default: count_next = count_reg;
    endcase

    case ({vec_done, vec_used})
      2'b10:   vec_count_next = vec_count_reg + VecW'(1);
      2'b01:   vec_count_next = vec_count_reg - VecW'(1);
      default: vec_count_next = vec_count_reg;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      vec_count_reg     <= '0;
      wr_idx_reg        <= '0;
      rd_idx_reg        <= '0;
      err_align_reg     <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg        <= wr_ptr_next;
      rd_ptr_reg        <= rd_ptr_next;
      count_reg         <= count_next;
      vec_count_reg     <= vec_count_next;
      wr_idx_reg        <= wr_idx_next;
      rd_idx_reg        <= rd_idx_next;
      err_align_reg     <= err_align_next;
      err_underflow_reg <= err_underflow_next;
    end
  end

  // Store contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk_in) begin
    if (push)
      store_mem[wr_ptr_reg] <= s_data;
  end

  assign head_chunk = store_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < WorkingRegs; gi++) begin : g_lane
      assign out_data[gi] = head_chunk[gi*NBits +: NBits];
    end
  endgenerate

  assign s_ready       = (count_reg < CntW'(D));
  assign in_data_ready = (vec_count_reg != '0);
  assign chunk_idx     = rd_idx_reg;
  assign err_align     = err_align_reg;
  assign err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_vec_chunk_feeder.sv
// Directed bench for vec_chunk_feeder: scoreboard queue of pushed chunks,
// compared against out_data at each pop, plus flag/index checks per step.
module tb_vec_chunk_feeder;

  logic                     clk_in;
  logic                     rst_in;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [3:0][7:0]   s_data;
  logic                     s_last;
  logic                     req_chunk_in;
  logic signed [3:0][7:0]   out_data;
  logic                     in_data_ready;
  logic [1:0]               chunk_idx;
  logic                     err_align;
  logic                     err_underflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] od;

  vec_chunk_feeder #(
    .InVecLength(16),
    .WorkingRegs(4),
    .NBits(8),
    .DepthVecs(2)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .req_chunk_in  (req_chunk_in),
    .out_data      (out_data),
    .in_data_ready (in_data_ready),
    .chunk_idx     (chunk_idx),
    .err_align     (err_align),
    .err_underflow (err_underflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mk(input int base);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(base + i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; pops compare the current head before the edge.
  task automatic xfer(input bit do_push, input bit acc, input int base, input bit last,
                      input bit do_pop, input int exp_idx, input string tag);
    logic [31:0] head;
    logic [31:0] want;
    if (do_pop) begin
      head = out_data;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
        n_cmp--;
        want = sb.pop_front();
        chk({tag, "_data"}, head, want);
      end
      chk({tag, "_idx"}, 32'(chunk_idx), 32'(exp_idx));
    end
    s_valid      = do_push;
    s_data       = mk(base);
    s_last       = last;
    req_chunk_in = do_pop;
    if (do_push && acc) sb.push_back(mk(base));
    $display("%0t %s push=%0d base=%0d last=%0d pop=%0d", $time, tag, do_push, base, last, do_pop);
    @(posedge clk_in); #1;
    s_valid      = 1'b0;
    s_last       = 1'b0;
    req_chunk_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; req_chunk_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_idr", 32'(in_data_ready), 32'd0);
    chk("rst_idx", 32'(chunk_idx), 32'd0);
    chk("rst_ealign", 32'(err_align), 32'd0);
    chk("rst_eunder", 32'(err_underflow), 32'd0);
    rst_in = 1'b1;

    // 1: one aligned vector in, then out
    xfer(1, 1, 1, 0, 0, 0, "t1_push0");
    od = out_data;
    chk("t1_latency", od, mk(1));
    chk("t1_idr0", 32'(in_data_ready), 32'd0);
    xfer(1, 1, 5, 0, 0, 0, "t1_push1");
    xfer(1, 1, 9, 0, 0, 0, "t1_push2");
    chk("t1_idr2", 32'(in_data_ready), 32'd0);
    xfer(1, 1, 13, 1, 0, 0, "t1_push3");
    chk("t1_idr_rise", 32'(in_data_ready), 32'd1);
    for (int k = 0; k < 3; k++) xfer(0, 0, 0, 0, 1, k, "t1_pop");
    chk("t1_idr_hold", 32'(in_data_ready), 32'd1);
    xfer(0, 0, 0, 0, 1, 3, "t1_pop3");
    chk("t1_idr_fall", 32'(in_data_ready), 32'd0);
    chk("t1_s_ready", 32'(s_ready), 32'd1);

    // 2: fill to capacity, back-pressure, release by a pop
    for (int k = 0; k < 8; k++) begin
      xfer(1, 1, 17 + 4*k, (k == 3) || (k == 7), 0, 0, "t2_push");
      if (k == 6) chk("t2_ready_7", 32'(s_ready), 32'd1);
    end
    chk("t2_full", 32'(s_ready), 32'd0);
    chk("t2_idr", 32'(in_data_ready), 32'd1);
    xfer(1, 0, 99, 0, 0, 0, "t2_held");
    chk("t2_still_full", 32'(s_ready), 32'd0);
    xfer(1, 0, 99, 0, 1, 0, "t2_pop_full");
    chk("t2_ready_back", 32'(s_ready), 32'd1);
    for (int k = 1; k < 4; k++) xfer(0, 0, 0, 0, 1, k, "t2_pop");
    chk("t2_idr_one_left", 32'(in_data_ready), 32'd1);
    xfer(1, 1, 49, 0, 0, 0, "t2_fill");
    xfer(1, 1, 53, 0, 0, 0, "t2_fill");
    xfer(1, 1, 57, 0, 0, 0, "t2_fill");
    chk("t2_ready_7buf", 32'(s_ready), 32'd1);

    // 3: simultaneous push/pop with 7 chunks held
    for (int k = 0; k < 5; k++) begin
      xfer(1, 1, 61 + 4*k, (k == 0) || (k == 4), 1, (k < 4) ? k : 0, "t3_pp");
      chk("t3_ready", 32'(s_ready), 32'd1);
      chk("t3_idr", 32'(in_data_ready), 32'd1);
    end
    for (int k = 0; k < 7; k++) xfer(0, 0, 0, 0, 1, (k + 1) % 4, "t3_drain");
    chk("t3_idr_end", 32'(in_data_ready), 32'd0);
    chk("t3_ready_end", 32'(s_ready), 32'd1);

    // 4: early s_last, then an aligned vector
    xfer(1, 1, 81, 0, 0, 0, "t4_short0");
    xfer(1, 1, 85, 1, 0, 0, "t4_short1");
    chk("t4_ealign", 32'(err_align), 32'd1);
    chk("t4_idr_short", 32'(in_data_ready), 32'd0);
    xfer(1, 1, 89, 0, 0, 0, "t4_push");
    xfer(1, 1, 93, 0, 0, 0, "t4_push");
    xfer(1, 1, 97, 0, 0, 0, "t4_push");
    chk("t4_idr_3", 32'(in_data_ready), 32'd0);
    xfer(1, 1, 101, 1, 0, 0, "t4_push_last");
    chk("t4_idr_rise", 32'(in_data_ready), 32'd1);
    for (int k = 0; k < 4; k++) xfer(0, 0, 0, 0, 1, k, "t4_pop");
    chk("t4_idr_fall", 32'(in_data_ready), 32'd0);
    xfer(0, 0, 0, 0, 1, 0, "t4_pop");
    xfer(0, 0, 0, 0, 1, 1, "t4_pop");
    chk("t4_ealign_sticky", 32'(err_align), 32'd1);

    // 5: pop on empty
    req_chunk_in = 1'b1;
    $display("%0t t5_underflow push=0 pop=1", $time);
    @(posedge clk_in); #1;
    req_chunk_in = 1'b0;
    chk("t5_eunder", 32'(err_underflow), 32'd1);
    chk("t5_idx_kept", 32'(chunk_idx), 32'd2);
    chk("t5_ready", 32'(s_ready), 32'd1);
    chk("t5_idr", 32'(in_data_ready), 32'd0);
    xfer(1, 1, 105, 0, 0, 0, "t5_push");
    xfer(1, 1, 109, 0, 0, 0, "t5_push");
    xfer(1, 1, 113, 0, 0, 0, "t5_push");
    xfer(1, 1, 117, 1, 0, 0, "t5_push_last");
    chk("t5_idr_rise", 32'(in_data_ready), 32'd1);
    xfer(0, 0, 0, 0, 1, 2, "t5_pop");
    xfer(0, 0, 0, 0, 1, 3, "t5_pop");
    chk("t5_idr_fall", 32'(in_data_ready), 32'd0);
    xfer(0, 0, 0, 0, 1, 0, "t5_pop");
    xfer(0, 0, 0, 0, 1, 1, "t5_pop");
    chk("t5_eunder_sticky", 32'(err_underflow), 32'd1);

    // 6: asynchronous reset mid-vector
    xfer(1, 1, 121, 0, 0, 0, "t6_push");
    xfer(1, 1, 125, 0, 0, 0, "t6_push");
    xfer(1, 1, 129, 0, 0, 0, "t6_push");
    chk("t6_idx_pre", 32'(chunk_idx), 32'd2);
    #2;
    rst_in = 1'b0;
    #1;
    $display("%0t t6_reset asserted", $time);
    chk("t6_rst_ready", 32'(s_ready), 32'd1);
    chk("t6_rst_idr", 32'(in_data_ready), 32'd0);
    chk("t6_rst_idx", 32'(chunk_idx), 32'd0);
    chk("t6_rst_ealign", 32'(err_align), 32'd0);
    chk("t6_rst_eunder", 32'(err_underflow), 32'd0);
    sb.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    xfer(1, 1, -16, 0, 0, 0, "t6_push");
    chk("t6_idr_1", 32'(in_data_ready), 32'd0);
    xfer(1, 1, -12, 0, 0, 0, "t6_push");
    xfer(1, 1, -8, 0, 0, 0, "t6_push");
    xfer(1, 1, -4, 1, 0, 0, "t6_push_last");
    chk("t6_idr_rise", 32'(in_data_ready), 32'd1);
    for (int k = 0; k < 4; k++) xfer(0, 0, 0, 0, 1, k, "t6_pop");
    chk("t6_idr_fall", 32'(in_data_ready), 32'd0);
    chk("t6_ealign_clean", 32'(err_align), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
